en_decoder_pipe: RTL and testbench
==================================

// Module: en_decoder_pipe
// PURPOSE
//  Parametrised, registered SEL_W-to-OUT_N one-hot decoder with enable.
//  Drives per-register write strobes for the RISC-V register file and
//  peripheral selects. Adds pipelining, x0 masking, out-of-range error
//  flagging and a sticky accumulate mode.
// PARAMETERS
//  SEL_W     5  select width
//  OUT_N    32  number of outputs; legal range 2..2**SEL_W
//  PIPE      1  register stages from sel/en to outputs; legal values 1 or 2
//  ZERO_MASK 1  1: sel==0 never asserts onehot_o[0] (x0 hard-wired zero)
//  STICKY    0  0: pulse mode; 1: accumulate mode (OR of hits until clr)
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  en        in   1      decode request this cycle
//  sel       in   SEL_W  index to decode, sampled when en=1
//  clr       in   1      STICKY=1: clear accumulated mask; ignored when STICKY=0
//  onehot_o  out  OUT_N  decoded strobes
//  valid_o   out  1      pulse: an en from PIPE cycles earlier has reached the output
//  err_o     out  1      pulse: that request had sel>=OUT_N
//  masked_o  out  1      pulse: that request was suppressed by ZERO_MASK
// BEHAVIOUR
//  - Reset (async assert, sync release): every pipeline register and output = 0.
//    Reset mid-operation flushes all in-flight requests; no output after release.
//  - Stage 0 classifies each request:
//    hit = en & (sel<OUT_N) & ~(ZERO_MASK & sel==0)
//    err = en & (sel>=OUT_N);  msk = en & ZERO_MASK & (sel==0)
//  - Latency is exactly PIPE cycles. A request at edge k appears at edge k+PIPE.
//    The pipeline accepts one request per cycle; there is no back-pressure.
//  - STICKY=0: onehot_o = hit ? (1<<sel) : 0 for one cycle. At most one bit is set.
//    en=0 gives all zero.
//  - STICKY=1: acc <= (clr_d ? 0 : acc) | (hit_d ? 1<<sel_d : 0), where clr is
//    delayed by PIPE-1 cycles to align with the request.
//    When clr and hit coincide, the new bit survives and all older bits clear.
//    A repeat hit on a set bit leaves the bit unchanged. onehot_o = acc.
//  - valid_o, err_o and masked_o are single-cycle pulses in both modes, aligned
//    with the onehot_o update. err and masked requests never change onehot_o.
//  - err and msk are mutually exclusive.
//  - With OUT_N < 2**SEL_W, the unused codes raise err_o.
//  - With OUT_N == 2**SEL_W, err_o stays at 0.
//  - sel is don't-care when en=0. X on sel with en=0 must not propagate.
// STRUCTURE
//  - Shared package decoder_pkg holds the mode constants DEC_PULSE=0 and
//    DEC_STICKY=1, plus the function onehot(sel, n) returning an n-bit vector.
//  - One sub-module, onehot_dec: combinational SEL_W to OUT_N with enable and range
//    check. It replaces the fixed 3-to-8 case-statement decoder.
//  - Pipeline: generate loop over PIPE stages of {en, hit, err, msk, sel, clr}.
//    The output stage holds the pulse register or acc, selected by STICKY.
//  - Elaboration check: error if OUT_N > 2**SEL_W or PIPE is not 1 or 2.
// TESTING
//  1 Defaults (PIPE=1, ZERO_MASK=1, STICKY=0); en=1 with sel=5, then en=0:
//    onehot_o=32'h20 and valid_o=1 for one cycle, one cycle later; then 0.
//  2 Defaults, en=1, sel=0: onehot_o=0, masked_o=1, valid_o=1, err_o=0.
//    Repeat with ZERO_MASK=0: onehot_o=32'h1, masked_o=0.
//  3 SEL_W=3, OUT_N=6: back-to-back sel=5,6,7,1 -> onehot_o=6'h20, 0, 0, 6'h02;
//    err_o=0,1,1,0. Sweep all 8 codes and compare against the 3-to-8 truth table.
//  4 STICKY=1: hit sel=3, sel=7, sel=3 -> onehot_o=08, 88, 88. Then clr together
//    with sel=1 -> 02. Then clr alone -> 0.
//  5 PIPE=2: en=1 sel=9 -> onehot_o[9] rises exactly 2 edges later.
//    Assert rst_n=0 while that request is in flight: outputs go 0 immediately and
//    stay 0 after release.
//  6 Random stream of 10k cycles in both modes, checked against a reference model.
//    Assertions: $onehot0(onehot_o) when STICKY=0; err_o & masked_o never both 1.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared mode constants and the one-hot expansion helper for the select decoder.
package decoder_pkg;

  typedef enum logic {
    DEC_PULSE  = 1'b0,
    DEC_STICKY = 1'b1
  } dec_mode_e;

  // Widest decode the helper supports; callers size-cast down to their own width.
  localparam int MAX_OUT = 1024;

  function automatic logic [MAX_OUT-1:0] onehot(input logic [31:0] sel, input logic [31:0] n);
    logic [MAX_OUT-1:0] vec;
    if ((sel < n) && (sel < 32'(MAX_OUT))) begin
      vec = {{(MAX_OUT-1){1'b0}}, 1'b1} << sel;
    end else begin
      vec = '0;
    end
    return vec;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W-to-OUT_N decoder with enable, range check and x0 masking.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int SEL_W     = 5,
  parameter int OUT_N     = 32,
  parameter int ZERO_MASK = 1
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_N-1:0] dec,
  output logic             hit,
  output logic             err,
  output logic             msk
);

  localparam logic MASK_X0 = (ZERO_MASK != 0);

  logic in_range_s;
  logic is_x0_s;

  // Every result is gated by en so an unknown sel while idle stays contained.
  always_comb begin
    in_range_s = (32'(sel) < 32'(OUT_N));
    is_x0_s    = MASK_X0 & (sel == '0);
    hit        = en & in_range_s & ~is_x0_s;
    err        = en & ~in_range_s;
    msk        = en & is_x0_s;
    if (hit) begin
      dec = OUT_N'(onehot(32'(sel), 32'(OUT_N)));
    end else begin
      dec = '0;
    end
  end

endmodule

// File: rtl/en_decoder_pipe.sv
// Registered, pipelined one-hot decoder with enable, x0 masking, error
// flagging and an optional sticky accumulate mode.
module en_decoder_pipe
  import decoder_pkg::*;
#(
  parameter int SEL_W     = 5,
  parameter int OUT_N     = 32,
  parameter int PIPE      = 1,
  parameter int ZERO_MASK = 1,
  parameter int STICKY    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  input  logic             clr,
  output logic [OUT_N-1:0] onehot_o,
  output logic             valid_o,
  output logic             err_o,
  output logic             masked_o
);

  if ((OUT_N > (2 ** SEL_W)) || (OUT_N < 2) || (OUT_N > MAX_OUT)) begin : g_bad_out_n
    $error("en_decoder_pipe: OUT_N must lie in 2..2**SEL_W");
  end
  if ((PIPE != 1) && (PIPE != 2)) begin : g_bad_pipe
    $error("en_decoder_pipe: PIPE must be 1 or 2");
  end

  localparam logic ACCUM = (STICKY == int'(DEC_STICKY));

  // The decoded strobe travels with the request so the output stage needs no decode.
  typedef struct packed {
    logic             en;
    logic             hit;
    logic             err;
    logic             msk;
    logic [OUT_N-1:0] dec;
    logic             clr;
  } stage_t;

  logic             dec_hit_s;
  logic             dec_err_s;
  logic             dec_msk_s;
  logic [OUT_N-1:0] dec_vec_s;
  stage_t           stage0_s;
  stage_t           last_s;

  onehot_dec #(
    .SEL_W    (SEL_W),
    .OUT_N    (OUT_N),
    .ZERO_MASK(ZERO_MASK)
  ) u_dec (
    .en (en),
    .sel(sel),
    .dec(dec_vec_s),
    .hit(dec_hit_s),
    .err(dec_err_s),
    .msk(dec_msk_s)
  );

  // Stage 0 request record built from the classifier.
  always_comb begin
    stage0_s.en  = en;
    stage0_s.hit = dec_hit_s;
    stage0_s.err = dec_err_s;
    stage0_s.msk = dec_msk_s;
    stage0_s.dec = dec_vec_s;
    stage0_s.clr = clr;
  end

  if (PIPE == 1) begin : g_pipe_direct
    assign last_s = stage0_s;
  end else begin : g_pipe_delay
    stage_t dly_r [PIPE-1];

    // Delay line; clr rides along so it lines up with its request.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE-1; i++) begin
          dly_r[i] <= '0;
        end
      end else begin
        dly_r[0] <= stage0_s;
        for (int i = 1; i < PIPE-1; i++) begin
          dly_r[i] <= dly_r[i-1];
        end
      end
    end

    assign last_s = dly_r[PIPE-2];
  end

  logic [OUT_N-1:0] strobe_s;
  logic [OUT_N-1:0] onehot_next_s;
  logic [OUT_N-1:0] onehot_r;
  logic             valid_r;
  logic             err_r;
  logic             msk_r;

  // Next output pattern: a single pulse, or the mask with clear applied before the new hit.
  always_comb begin
    if (last_s.hit) begin
      strobe_s = last_s.dec;
    end else begin
      strobe_s = '0;
    end
    if (ACCUM) begin
      if (last_s.clr) begin
        onehot_next_s = strobe_s;
      end else begin
        onehot_next_s = onehot_r | strobe_s;
      end
    end else begin
      onehot_next_s = strobe_s;
    end
  end

  // Output stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_r <= '0;
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
      msk_r    <= 1'b0;
    end else begin
      onehot_r <= onehot_next_s;
      valid_r  <= last_s.en;
      err_r    <= last_s.err;
      msk_r    <= last_s.msk;
    end
  end

  assign onehot_o = onehot_r;
  assign valid_o  = valid_r;
  assign err_o    = err_r;
  assign masked_o = msk_r;

endmodule

// File: tb/tb_en_decoder_pipe.sv
// Bench for en_decoder_pipe: six parameter sets share one stimulus stream and
// are compared every cycle against a behavioural model, plus literal spot checks.
module tb_en_decoder_pipe;

  localparam int NC = 6;
  localparam int CFG_SW [NC] = '{5, 5, 3, 3, 5, 4};
  localparam int CFG_N  [NC] = '{32, 32, 6, 8, 32, 12};
  localparam int CFG_P  [NC] = '{1, 1, 1, 1, 2, 2};
  localparam int CFG_ZM [NC] = '{1, 0, 1, 1, 1, 0};
  localparam int CFG_ST [NC] = '{0, 0, 0, 1, 0, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [4:0] sel;
  logic       clr;

  logic [31:0] oh0, oh1, oh4;
  logic [5:0]  oh2;
  logic [7:0]  oh3;
  logic [11:0] oh5;
  logic [NC-1:0] v_o, e_o, m_o;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  en_decoder_pipe #(.SEL_W(5), .OUT_N(32), .PIPE(1), .ZERO_MASK(1), .STICKY(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .clr(clr),
    .onehot_o(oh0), .valid_o(v_o[0]), .err_o(e_o[0]), .masked_o(m_o[0]));
  en_decoder_pipe #(.SEL_W(5), .OUT_N(32), .PIPE(1), .ZERO_MASK(0), .STICKY(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .clr(clr),
    .onehot_o(oh1), .valid_o(v_o[1]), .err_o(e_o[1]), .masked_o(m_o[1]));
  en_decoder_pipe #(.SEL_W(3), .OUT_N(6), .PIPE(1), .ZERO_MASK(1), .STICKY(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel[2:0]), .clr(clr),
    .onehot_o(oh2), .valid_o(v_o[2]), .err_o(e_o[2]), .masked_o(m_o[2]));
  en_decoder_pipe #(.SEL_W(3), .OUT_N(8), .PIPE(1), .ZERO_MASK(1), .STICKY(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel[2:0]), .clr(clr),
    .onehot_o(oh3), .valid_o(v_o[3]), .err_o(e_o[3]), .masked_o(m_o[3]));
  en_decoder_pipe #(.SEL_W(5), .OUT_N(32), .PIPE(2), .ZERO_MASK(1), .STICKY(0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .clr(clr),
    .onehot_o(oh4), .valid_o(v_o[4]), .err_o(e_o[4]), .masked_o(m_o[4]));
  en_decoder_pipe #(.SEL_W(4), .OUT_N(12), .PIPE(2), .ZERO_MASK(0), .STICKY(1)) u_d5 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel[3:0]), .clr(clr),
    .onehot_o(oh5), .valid_o(v_o[5]), .err_o(e_o[5]), .masked_o(m_o[5]));

  logic [31:0] act_oh [NC];
  always_comb begin
    act_oh[0] = oh0;
    act_oh[1] = oh1;
    act_oh[2] = 32'(oh2);
    act_oh[3] = 32'(oh3);
    act_oh[4] = oh4;
    act_oh[5] = 32'(oh5);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the output after an edge reflects the request sampled
  // PIPE-1 edges earlier; sticky configs OR hits into a set, clr empties it first.
  logic [31:0] exp_oh [NC];
  bit          exp_v [NC], exp_e [NC], exp_m [NC];
  bit          cur_en, cur_clr, prev_en, prev_clr, r_en, r_clr, in_rng, is_x0, hit;
  int          cur_sel, prev_sel, r_sel, s;
  logic [31:0] strobe;

  initial begin
    for (int c = 0; c < NC; c++) begin
      exp_oh[c] = 32'd0; exp_v[c] = 1'b0; exp_e[c] = 1'b0; exp_m[c] = 1'b0;
    end
    prev_en = 1'b0; prev_clr = 1'b0; prev_sel = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int c = 0; c < NC; c++) begin
          exp_oh[c] = 32'd0; exp_v[c] = 1'b0; exp_e[c] = 1'b0; exp_m[c] = 1'b0;
        end
        prev_en = 1'b0; prev_clr = 1'b0; prev_sel = 0;
      end else begin
        cur_en  = (en === 1'b1);
        cur_clr = (clr === 1'b1);
        cur_sel = cur_en ? int'(sel) : 0;
        for (int c = 0; c < NC; c++) begin
          r_en   = (CFG_P[c] == 1) ? cur_en  : prev_en;
          r_clr  = (CFG_P[c] == 1) ? cur_clr : prev_clr;
          r_sel  = (CFG_P[c] == 1) ? cur_sel : prev_sel;
          s      = r_sel % (1 << CFG_SW[c]);
          in_rng = (s < CFG_N[c]);
          is_x0  = (CFG_ZM[c] != 0) && (s == 0);
          hit    = r_en && in_rng && !is_x0;
          strobe = hit ? (32'd1 << s) : 32'd0;
          if (CFG_ST[c] != 0) exp_oh[c] = (r_clr ? 32'd0 : exp_oh[c]) | strobe;
          else                exp_oh[c] = strobe;
          exp_v[c] = r_en;
          exp_e[c] = r_en && !in_rng;
          exp_m[c] = r_en && is_x0;
        end
        prev_en = cur_en; prev_clr = cur_clr; prev_sel = cur_sel;
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("cfg%0d onehot", c), act_oh[c], exp_oh[c]);
        chk($sformatf("cfg%0d valid", c), 32'(v_o[c]), 32'(exp_v[c]));
        chk($sformatf("cfg%0d err", c), 32'(e_o[c]), 32'(exp_e[c]));
        chk($sformatf("cfg%0d masked", c), 32'(m_o[c]), 32'(exp_m[c]));
        chk($sformatf("cfg%0d err_and_masked", c), 32'(e_o[c] & m_o[c]), 32'd0);
        if (CFG_ST[c] == 0) chk($sformatf("cfg%0d onehot0", c), 32'($onehot0(act_oh[c])), 32'd1);
      end
    end
  end

  task automatic cyc(input logic e, input logic [4:0] sv, input logic c);
    en = e; sel = sv; clr = c;
    @(negedge clk);
  endtask

  logic [5:0] tt [8];
  logic [7:0] err_tt;

  initial begin
    tt     = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h00, 6'h00};
    err_tt = 8'b1100_0000;
    rst_n = 1'b0; en = 1'b0; sel = 5'd0; clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset onehot", oh0, 32'd0);
    chk("reset valid", 32'(v_o[0]), 32'd0);
    chk_en = 1'b1;

    // basic pulse and PIPE=2 latency
    cyc(1'b1, 5'd5, 1'b0);
    chk("t1 onehot", oh0, 32'h20);
    chk("t1 valid", 32'(v_o[0]), 32'd1);
    chk("t1 pipe2 early", oh4, 32'd0);
    cyc(1'b0, 5'd0, 1'b0);
    chk("t1 onehot idle", oh0, 32'd0);
    chk("t1 valid idle", 32'(v_o[0]), 32'd0);
    chk("t1 pipe2 onehot", oh4, 32'h20);

    // x0 masking
    cyc(1'b1, 5'd0, 1'b0);
    chk("t2 onehot", oh0, 32'd0);
    chk("t2 masked", 32'(m_o[0]), 32'd1);
    chk("t2 valid", 32'(v_o[0]), 32'd1);
    chk("t2 err", 32'(e_o[0]), 32'd0);
    chk("t2 nomask onehot", oh1, 32'h1);
    chk("t2 nomask masked", 32'(m_o[1]), 32'd0);

    // OUT_N=6 back-to-back and full code sweep
    cyc(1'b1, 5'd5, 1'b0); chk("t3 sel5", 32'(oh2), 32'h20); chk("t3 err5", 32'(e_o[2]), 32'd0);
    cyc(1'b1, 5'd6, 1'b0); chk("t3 sel6", 32'(oh2), 32'h00); chk("t3 err6", 32'(e_o[2]), 32'd1);
    cyc(1'b1, 5'd7, 1'b0); chk("t3 sel7", 32'(oh2), 32'h00); chk("t3 err7", 32'(e_o[2]), 32'd1);
    cyc(1'b1, 5'd1, 1'b0); chk("t3 sel1", 32'(oh2), 32'h02); chk("t3 err1", 32'(e_o[2]), 32'd0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 5'(k), 1'b0);
      chk($sformatf("t3 sweep onehot %0d", k), 32'(oh2), 32'(tt[k]));
      chk($sformatf("t3 sweep err %0d", k), 32'(e_o[2]), 32'(err_tt[k]));
    end

    // sticky accumulate
    cyc(1'b0, 5'd0, 1'b1); chk("t4 cleared", 32'(oh3), 32'h00);
    cyc(1'b1, 5'd3, 1'b0); chk("t4 hit3", 32'(oh3), 32'h08);
    cyc(1'b1, 5'd7, 1'b0); chk("t4 hit7", 32'(oh3), 32'h88);
    cyc(1'b1, 5'd3, 1'b0); chk("t4 rehit3", 32'(oh3), 32'h88);
    cyc(1'b1, 5'd1, 1'b1); chk("t4 clr+hit1", 32'(oh3), 32'h02);
    cyc(1'b0, 5'd0, 1'b1); chk("t4 clr alone", 32'(oh3), 32'h00);

    // PIPE=2 latency and reset flush of an in-flight request
    cyc(1'b1, 5'd9, 1'b0); chk("t5 one edge", oh4, 32'd0);
    cyc(1'b0, 5'd0, 1'b0); chk("t5 two edges", oh4, 32'h200);
    cyc(1'b1, 5'd9, 1'b0); chk("t5 pipe1 before reset", oh0, 32'h200);
    #2 rst_n = 1'b0; en = 1'b0; sel = 5'd0;
    #1;
    chk("t5 reset onehot", oh0, 32'd0);
    chk("t5 reset valid", 32'(v_o[0]), 32'd0);
    chk("t5 reset sticky", 32'(oh3), 32'd0);
    chk("t5 reset pipe2", oh4, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 5'd0, 1'b0);
      chk($sformatf("t5 flushed onehot %0d", k), oh4, 32'd0);
      chk($sformatf("t5 flushed valid %0d", k), 32'(v_o[4]), 32'd0);
    end

    // random stream, idle cycles sometimes carry an unknown sel
    for (int k = 0; k < 10000; k++) begin
      logic       re, rc;
      logic [4:0] rs;
      re = ($urandom_range(0, 9) < 7);
      rc = ($urandom_range(0, 9) == 0);
      rs = 5'($urandom_range(0, 31));
      if (!re && ($urandom_range(0, 3) == 0)) rs = 5'bxxxxx;
      cyc(re, rs, rc);
    end
    repeat (3) cyc(1'b0, 5'd0, 1'b0);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
